// File: rtl/d_branch_unit_if.sv
// Bundles the D-stage branch operands, BHT indices and the resolve/prediction results.
// The master drives the operands; the slave (the branch unit) drives the results.
interface d_branch_unit_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BHT_DEPTH = 16
);
   localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

   logic [WIDTH-1:0] rsData;
   logic [WIDTH-1:0] rtData;
   logic [2:0]       br_op;
   logic             d_valid;
   logic             stall;
   logic [IDX_W-1:0] d_idx;
   logic             d_pred;
   logic [IDX_W-1:0] f_idx;
   logic             judge;
   logic             f_pred;
   logic             mispredict;
   logic [31:0]      br_cnt;
   logic [31:0]      miss_cnt;

   modport master (
      output rsData, rtData, br_op, d_valid, stall, d_idx, d_pred, f_idx,
      input  judge, f_pred, mispredict, br_cnt, miss_cnt
   );

   modport slave (
      input  rsData, rtData, br_op, d_valid, stall, d_idx, d_pred, f_idx,
      output judge, f_pred, mispredict, br_cnt, miss_cnt
   );
endinterface

// File: rtl/d_branch_unit.sv
// D-stage branch resolution: combinational taken decision, 2-bit saturating BHT,
// one-cycle mispredict flush request and saturating resolve/miss counters.
module d_branch_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BHT_DEPTH = 16
) (
   input logic            clk,
   input logic            reset,
   d_branch_unit_if.slave bus
);
   typedef enum logic [2:0] {
      OpNone = 3'b000,
      OpBeq  = 3'b001,
      OpBne  = 3'b010,
      OpBlez = 3'b011,
      OpBgtz = 3'b100,
      OpBltz = 3'b101,
      OpBgez = 3'b110,
      OpRsvd = 3'b111
   } br_op_e;

   logic        rs_neg;
   logic        rs_zero;
   logic        judge;
   logic        resolve;
   logic [1:0]  ctr_cur;
   logic [1:0]  ctr_nxt;
   logic        mispredict_q;
   logic [31:0] br_cnt_q;
   logic [31:0] miss_cnt_q;
   logic [1:0]  bht_q [BHT_DEPTH];

   always_comb begin
      rs_neg  = bus.rsData[WIDTH-1];
      rs_zero = (bus.rsData == '0);
      judge   = 1'b0;
      case (br_op_e'(bus.br_op))
         OpBeq:   judge = (bus.rsData == bus.rtData);
         OpBne:   judge = (bus.rsData != bus.rtData);
         OpBlez:  judge = rs_neg | rs_zero;
         OpBgtz:  judge = ~rs_neg & ~rs_zero;
         OpBltz:  judge = rs_neg;
         OpBgez:  judge = ~rs_neg;
         default: judge = 1'b0;
      endcase
   end

   always_comb begin
      resolve = bus.d_valid && !bus.stall &&
                (bus.br_op != OpNone) && (bus.br_op != OpRsvd);
      ctr_cur = bht_q[bus.d_idx];
      ctr_nxt = ctr_cur;
      if (judge && ctr_cur != 2'b11) begin
         ctr_nxt = ctr_cur + 2'd1;
      end else if (!judge && ctr_cur != 2'b00) begin
         ctr_nxt = ctr_cur - 2'd1;
      end
   end

   // Entries reset to weakly not-taken; the write lands at the edge, so a same-cycle
   // F-stage read of the same index still sees the old counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(BHT_DEPTH); i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (resolve) begin
         bht_q[bus.d_idx] <= ctr_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mispredict_q <= 1'b0;
         br_cnt_q     <= '0;
         miss_cnt_q   <= '0;
      end else begin
         mispredict_q <= resolve && (judge != bus.d_pred);
         if (resolve && br_cnt_q != 32'hFFFF_FFFF) begin
            br_cnt_q <= br_cnt_q + 32'd1;
         end
         if (resolve && (judge != bus.d_pred) && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign bus.judge      = judge;
   assign bus.f_pred     = reset ? 1'b0 : bht_q[bus.f_idx][1];
   assign bus.mispredict = mispredict_q;
   assign bus.br_cnt     = br_cnt_q;
   assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_d_branch_unit.sv
// Bench for d_branch_unit: judge vector table, directed corner sequences and random
// traffic checked against a counter-array reference model.
module tb_d_branch_unit;
   localparam int unsigned WIDTH     = 32;
   localparam int unsigned BHT_DEPTH = 16;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   // Reference model state.
   int   bht_m [BHT_DEPTH];
   int   br_m;
   int   miss_m;
   bit   misp_m;

   d_branch_unit_if #(.WIDTH(WIDTH), .BHT_DEPTH(BHT_DEPTH)) bus ();

   d_branch_unit #(.WIDTH(WIDTH), .BHT_DEPTH(BHT_DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        exp;
   } jvec_t;

   jvec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic ref_judge(input logic [2:0] op, input logic [31:0] rs,
                                      input logic [31:0] rt);
      int s;
      s = $signed(rs);
      case (op)
         3'd1:    return rs == rt;
         3'd2:    return rs != rt;
         3'd3:    return s <= 0;
         3'd4:    return s > 0;
         3'd5:    return s < 0;
         3'd6:    return s >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_m[i] = 1;
      br_m   = 0;
      miss_m = 0;
      misp_m = 0;
   endtask

   // Drive one D-stage cycle, check the combinational outputs before the edge and the
   // registered outputs just after it.
   task automatic do_cycle(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic v, input logic st, input logic [3:0] di,
                           input logic dp, input logic [3:0] fi);
      logic j;
      bit   res;
      @(negedge clk);
      bus.br_op   = op;
      bus.rsData  = rs;
      bus.rtData  = rt;
      bus.d_valid = v;
      bus.stall   = st;
      bus.d_idx   = di;
      bus.d_pred  = dp;
      bus.f_idx   = fi;
      #1;
      j = ref_judge(op, rs, rt);
      chk("judge", {63'd0, bus.judge}, {63'd0, j});
      chk("f_pred", {63'd0, bus.f_pred}, {63'd0, (bht_m[fi] >= 2)});
      res = v && !st && (op >= 3'd1) && (op <= 3'd6);
      @(posedge clk);
      #1;
      if (res) begin
         bht_m[di] = j ? ((bht_m[di] < 3) ? bht_m[di] + 1 : 3)
                       : ((bht_m[di] > 0) ? bht_m[di] - 1 : 0);
         br_m++;
         if (j != dp) miss_m++;
         misp_m = (j != dp);
      end else begin
         misp_m = 0;
      end
      chk("mispredict", {63'd0, bus.mispredict}, {63'd0, misp_m});
      chk("br_cnt", {32'd0, bus.br_cnt}, br_m);
      chk("miss_cnt", {32'd0, bus.miss_cnt}, miss_m);
   endtask

   initial begin
      logic [31:0] rs;
      logic [31:0] rt;
      checks   = 0;
      failures = 0;
      clk      = 1'b0;
      reset    = 1'b1;
      bus.br_op   = 3'd0;
      bus.rsData  = '0;
      bus.rtData  = '0;
      bus.d_valid = 1'b0;
      bus.stall   = 1'b0;
      bus.d_idx   = '0;
      bus.d_pred  = 1'b0;
      bus.f_idx   = '0;
      model_reset();

      tbl[0]  = '{3'd3, 32'h8000_0000, 32'h0, 1'b1};
      tbl[1]  = '{3'd5, 32'h8000_0000, 32'h0, 1'b1};
      tbl[2]  = '{3'd4, 32'h8000_0000, 32'h0, 1'b0};
      tbl[3]  = '{3'd6, 32'h8000_0000, 32'h0, 1'b0};
      tbl[4]  = '{3'd3, 32'h0,         32'h0, 1'b1};
      tbl[5]  = '{3'd6, 32'h0,         32'h0, 1'b1};
      tbl[6]  = '{3'd5, 32'h0,         32'h0, 1'b0};
      tbl[7]  = '{3'd4, 32'h0,         32'h0, 1'b0};
      tbl[8]  = '{3'd4, 32'h0000_0001, 32'h0, 1'b1};
      tbl[9]  = '{3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
      tbl[10] = '{3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0};
      tbl[11] = '{3'd2, 32'h1234_5678, 32'h1234_5679, 1'b1};
      tbl[12] = '{3'd0, 32'h5,         32'h5, 1'b0};
      tbl[13] = '{3'd7, 32'h5,         32'h5, 1'b0};

      // Reset state, judge live during reset.
      #12;
      chk("rst_mispredict", {63'd0, bus.mispredict}, 64'd0);
      chk("rst_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
      chk("rst_miss_cnt", {32'd0, bus.miss_cnt}, 64'd0);
      chk("rst_f_pred", {63'd0, bus.f_pred}, 64'd0);
      bus.br_op  = 3'd1;
      bus.rsData = 32'h5;
      bus.rtData = 32'h5;
      #1;
      chk("rst_judge", {63'd0, bus.judge}, 64'd1);
      @(negedge clk);
      reset = 1'b0;

      // beq taken with predicted not-taken at index 3.
      do_cycle(3'd1, 32'h5, 32'h5, 1'b1, 1'b0, 4'd3, 1'b0, 4'd3);
      chk("beq_br_cnt_abs", {32'd0, bus.br_cnt}, 64'd1);
      chk("beq_miss_abs", {32'd0, bus.miss_cnt}, 64'd1);
      do_cycle(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3);

      // Three taken then one not-taken at index 7, watched from F.
      for (int k = 0; k < 3; k++) do_cycle(3'd6, 32'h1, 32'h0, 1'b1, 1'b0, 4'd7, 1'b1, 4'd7);
      do_cycle(3'd5, 32'h1, 32'h0, 1'b1, 1'b0, 4'd7, 1'b0, 4'd7);
      do_cycle(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7);

      // Read-before-write on a shared index.
      do_cycle(3'd1, 32'h9, 32'h9, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2);
      do_cycle(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2);

      // Stall and reserved opcode leave all state alone.
      do_cycle(3'd2, 32'h1, 32'h2, 1'b1, 1'b1, 4'd4, 1'b0, 4'd4);
      do_cycle(3'd7, 32'h1, 32'h2, 1'b1, 1'b0, 4'd4, 1'b0, 4'd4);
      do_cycle(3'd1, 32'h1, 32'h1, 1'b0, 1'b0, 4'd4, 1'b0, 4'd4);

      // Judge decode table.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         bus.br_op   = tbl[i].op;
         bus.rsData  = tbl[i].rs;
         bus.rtData  = tbl[i].rt;
         bus.d_valid = 1'b0;
         #1;
         chk($sformatf("tbl_judge_%0d", i), {63'd0, bus.judge}, {63'd0, tbl[i].exp});
      end

      // Asynchronous reset between edges after a mispredict.
      do_cycle(3'd2, 32'h3, 32'h3, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("async_mispredict", {63'd0, bus.mispredict}, 64'd0);
      chk("async_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
      chk("async_miss_cnt", {32'd0, bus.miss_cnt}, 64'd0);
      bus.d_valid = 1'b1;
      bus.br_op   = 3'd1;
      bus.rsData  = 32'h7;
      bus.rtData  = 32'h7;
      bus.d_idx   = 4'd3;
      @(posedge clk);
      #1;
      chk("hold_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
      reset = 1'b0;
      model_reset();
      do_cycle(3'd1, 32'h7, 32'h7, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3);
      do_cycle(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       rs = 32'h0;
            1:       rs = 32'h8000_0000 | $urandom_range(0, 3);
            2:       rs = $urandom_range(0, 3);
            default: rs = $urandom;
         endcase
         rt = $urandom_range(0, 1) ? rs : $urandom_range(0, 3);
         do_cycle(3'($urandom_range(0, 7)), rs, rt, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
